// File: rtl/wb_unit.sv
// Writeback unit: commits ALU/LINK results in one cycle, and holds one
// outstanding load in WAIT_MEM until its response arrives or it is flushed.
// Extracted load data is sign/zero-extended before the register-file write.
module wb_unit #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [1:0]        m_wb_sel,
    input  logic              m_write_reg,
    input  logic [REG_AW-1:0] m_dest,
    input  logic [DATA_W-1:0] m_alu_result,
    input  logic [DATA_W-1:0] m_link,
    input  logic [1:0]        m_ld_size,
    input  logic              m_ld_signed,
    input  logic [OFF_W-1:0]  m_byte_off,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy
);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    // Everything needed to finish a load once the data comes back
    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic              write_reg;
        logic [1:0]        size;
        logic              sgn;
        logic [OFF_W-1:0]  off;
    } ld_ctx_t;

    state_t            state_q, state_d;
    ld_ctx_t           ctx_q, ctx_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;

    assign m_ready  = (state_q == IDLE);
    assign busy     = (state_q == WAIT_MEM);
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // Select the addressed lane and extend it; halfword ignores offset bit 0
    always_comb begin
        ld_byte = '0;
        ld_half = '0;
        for (int i = 0; i < DATA_W / 8; i++)
            if (ctx_q.off == OFF_W'(i)) ld_byte = mem_rsp_data[i*8 +: 8];
        for (int i = 0; i < DATA_W / 16; i++)
            if (ctx_q.off[OFF_W-1:1] == (OFF_W-1)'(i)) ld_half = mem_rsp_data[i*16 +: 16];
        case (ctx_q.size)
            2'b00:   ld_data = {{(DATA_W-8){ctx_q.sgn & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{(DATA_W-16){ctx_q.sgn & ld_half[15]}}, ld_half};
            default: ld_data = mem_rsp_data;
        endcase
    end

    // Next state, load capture and the registered write strobe
    always_comb begin
        state_d    = state_q;
        ctx_d      = ctx_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        case (state_q)
            IDLE: begin
                // m_ready is high here, so m_valid alone means accept
                if (m_valid && !flush) begin
                    if (m_wb_sel == 2'b01) begin
                        ctx_d.dest      = m_dest;
                        ctx_d.write_reg = m_write_reg;
                        ctx_d.size      = m_ld_size;
                        ctx_d.sgn       = m_ld_signed;
                        ctx_d.off       = m_byte_off;
                        state_d         = WAIT_MEM;
                    end else if (m_write_reg && m_wb_sel != 2'b11 && m_dest != '0) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = m_dest;
                        rf_wdata_d = (m_wb_sel == 2'b10) ? m_link : m_alu_result;
                    end
                end
            end
            WAIT_MEM: begin
                // Flush wins over a coincident response
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rsp_valid) begin
                    state_d = IDLE;
                    if (ctx_q.write_reg && ctx_q.dest != '0) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = ctx_q.dest;
                        rf_wdata_d = ld_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ctx_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width; multiple of 8, minimum 32.
REQ-002 SHALL have parameter REG_AW, default 5: register-file address width.
REQ-003 SHALL have derived localparam OFF_W = log2(DATA_W/8): byte-offset width.
REQ-004 SHALL have port clk  in  1  -- the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  -- asynchronous, active-low reset.
REQ-006 SHALL have port m_valid  in  1  -- MEM stage presents an instruction.
REQ-007 SHALL have port m_ready  out  1  -- unit accepts this cycle; transfer when m_valid & m_ready.
REQ-008 SHALL have port m_wb_sel  in  2  -- result source: 00 ALU, 01 MEM, 10 LINK, 11 none.
REQ-009 SHALL have port m_write_reg  in  1  -- instruction writes a register.
REQ-010 SHALL have port m_dest  in  REG_AW  -- destination register.
REQ-011 SHALL have port m_alu_result  in  DATA_W  -- ALU result.
REQ-012 SHALL have port m_link  in  DATA_W  -- return address for link instructions.
REQ-013 SHALL have port m_ld_size  in  2  -- 00 byte, 01 half, 10/11 word.
REQ-014 SHALL have port m_ld_signed  in  1  -- 1 sign-extends, 0 zero-extends.
REQ-015 SHALL have port m_byte_off  in  OFF_W  -- load address low bits.
REQ-016 SHALL have port mem_rsp_valid  in  1  -- load data valid.
REQ-017 SHALL have port mem_rsp_data  in  DATA_W  -- raw aligned memory word.
REQ-018 SHALL have port flush  in  1  -- kill the instruction accepted or pending this cycle.
REQ-019 SHALL have port rf_we  out  1  -- register-file write strobe.
REQ-020 SHALL have port rf_waddr  out  REG_AW  -- write address.
REQ-021 SHALL have port rf_wdata  out  DATA_W  -- write data.
REQ-022 SHALL have port busy  out  1  -- load outstanding (state WAIT_MEM).

Function
REQ-023 SHALL implement FSM states IDLE and WAIT_MEM; m_ready = 1 only in IDLE.
REQ-024 SHALL, in IDLE on accept with m_wb_sel != 01 and no flush, register rf_we/rf_waddr/rf_wdata so the write appears exactly one cycle after accept, with state remaining IDLE (one instruction per cycle).
REQ-025 SHALL, in IDLE on accept with m_wb_sel = 01 and no flush, capture m_dest, m_write_reg, m_ld_size, m_ld_signed, m_byte_off, and move to WAIT_MEM, with rf_we = 0 in the following cycle.
REQ-026 SHALL, in WAIT_MEM on mem_rsp_valid without flush, extract and extend the load, present the write one cycle later, and return to IDLE.
REQ-027 SHALL extract load data as follows: byte = byte lane m_byte_off; half = halfword at m_byte_off with bit 0 forced to 0; word = whole mem_rsp_data with offset ignored; the extension to DATA_W is by the captured signed flag.
REQ-028 SHALL keep rf_we at 0 for any committed instruction with m_write_reg = 0, m_wb_sel = 11, or dest = 0.
REQ-029 SHALL pulse rf_we for exactly one cycle per commit, with rf_waddr/rf_wdata holding their last values when rf_we = 0.
REQ-030 SHALL make flush in IDLE coincident with accept drop that instruction (no write); flush in WAIT_MEM returns to IDLE with no write, even if mem_rsp_valid is also asserted.
REQ-031 SHALL ignore mem_rsp_valid in IDLE (a late response after flush is discarded).
REQ-032 SHALL tolerate unbounded stay in WAIT_MEM; m_ready stays 0 throughout.

Reset
REQ-033 SHALL, on rst low, immediately force state to IDLE and rf_we, rf_waddr, rf_wdata, busy and captured fields to 0, with m_ready = 1 after release.
REQ-034 SHALL, on reset during WAIT_MEM, abandon the pending load with no write; a subsequent response is ignored.

Verification
REQ-035 SHALL verify ALU back-to-back: accept sel=00 dest=3 alu=0x12345678 then dest=4 alu=0x9 on consecutive cycles -> rf_we high two consecutive cycles, (3,0x12345678) then (4,0x9).
REQ-036 SHALL verify signed byte load: sel=01 dest=5 size=00 signed=1 off=2, rsp 3 cycles later data=0x00800000 -> busy 3 cycles, then write (5,0xFFFFFF80); m_ready=0 while busy.
REQ-037 SHALL verify unsigned half load with odd offset: size=01 signed=0 off=3, data=0xBEEF1234 -> write 0x0000BEEF.
REQ-038 SHALL verify suppression: sel=10 dest=0 link=0x40, and sel=00 write_reg=0 -> rf_we stays 0.
REQ-039 SHALL verify flush: load accepted, flush and mem_rsp_valid same cycle in WAIT_MEM -> no write, IDLE next cycle; second rsp pulse ignored.
REQ-040 SHALL verify reset mid-load: rst low in WAIT_MEM -> outputs 0 asynchronously; after release, rsp pulse gives no write and m_ready=1.
